// File: rtl/agc_pkg.sv
// Shared state encoding, default constants and decision helper for the AGC controller.
package agc_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned GAIN_W = 8;

   localparam int unsigned        DEF_WINDOW    = 1024;
   localparam int unsigned        DEF_HOLD      = 64;
   localparam logic [DATA_W-1:0]  DEF_HI_THRESH = 16'h0C00;
   localparam logic [DATA_W-1:0]  DEF_LO_THRESH = 16'h0300;
   localparam logic [GAIN_W-1:0]  DEF_GAIN_INIT = 8'd4;
   localparam logic [GAIN_W-1:0]  DEF_GAIN_MAX  = 8'd31;

   // Sample level that triggers an immediate gain drop when fast attack is built in.
   localparam logic [DATA_W-1:0]  FAST_ATTACK_LEVEL = 16'hF000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DECIDE  = 2'd2,
      SETTLE  = 2'd3
   } agc_state_t;

   typedef struct packed {
      logic dec;
      logic inc;
      logic ovl;
   } agc_decision_t;

   function automatic int unsigned cnt_width(input int unsigned window,
                                             input int unsigned hold);
      return $clog2(((window > hold) ? window : hold) + 1);
   endfunction

   // Window-end decision; threshold-equal peaks leave gain alone.
   function automatic agc_decision_t agc_decide(input logic [DATA_W-1:0] peak,
                                                input logic [GAIN_W-1:0] gain,
                                                input logic [DATA_W-1:0] hi,
                                                input logic [DATA_W-1:0] lo,
                                                input logic [GAIN_W-1:0] gmax);
      agc_decision_t d;
      d.dec = (peak > hi) && (gain != '0);
      d.inc = !d.dec && (peak < lo) && (gain < gmax);
      d.ovl = (peak > hi) && (gain == '0);
      return d;
   endfunction

endpackage

// File: rtl/agc_peak_detect.sv
// Running maximum of valid demod samples, cleared at the start of each window.
module agc_peak_detect
   import agc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] peak
);

   logic [DATA_W-1:0] peak_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q <= '0;
      end else if (clear) begin
         peak_q <= '0;
      end else if (sample_valid && (sample > peak_q)) begin
         peak_q <= sample;
      end
   end

   assign peak = peak_q;

endmodule

// File: rtl/agc_ctrl.sv
// Peak-based AGC loop: measure a window of demod samples, step CIC gain, settle.
// Optional build macro AGC_FAST_ATTACK_EN adds an immediate gain drop on near-full-scale samples.
module agc_ctrl
   import agc_pkg::*;
#(
   parameter int unsigned       WINDOW    = DEF_WINDOW,
   parameter int unsigned       HOLD      = DEF_HOLD,
   parameter logic [DATA_W-1:0] HI_THRESH = DEF_HI_THRESH,
   parameter logic [DATA_W-1:0] LO_THRESH = DEF_LO_THRESH,
   parameter logic [GAIN_W-1:0] GAIN_INIT = DEF_GAIN_INIT,
   parameter logic [GAIN_W-1:0] GAIN_MAX  = DEF_GAIN_MAX
) (
   input  logic              clk,
   input  logic              RSTb,
   input  logic [DATA_W-1:0] demod_in,
   input  logic              in_tick,
   input  logic              enable,
   output logic [GAIN_W-1:0] gain_out,
   output logic              gain_strobe,
   output logic              overload
);

   localparam int unsigned      CNT_W     = cnt_width(WINDOW, HOLD);
   localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

   agc_state_t        state_q, state_d;
   logic [GAIN_W-1:0] gain_q, gain_d;
   logic              strobe_q, strobe_d;
   logic              overload_q, overload_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              peak_clear;
   logic              peak_update;
   logic [DATA_W-1:0] peak;
   agc_decision_t     decision;
   logic              fast_hit;

   agc_peak_detect u_peak (
      .clk          (clk),
      .rst_n        (RSTb),
      .clear        (peak_clear),
      .sample_valid (peak_update),
      .sample       (demod_in),
      .peak         (peak)
   );

   always_ff @(posedge clk or negedge RSTb) begin
      if (!RSTb) begin
         state_q    <= IDLE;
         gain_q     <= GAIN_INIT;
         strobe_q   <= 1'b0;
         overload_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         gain_q     <= gain_d;
         strobe_q   <= strobe_d;
         overload_q <= overload_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gain_d      = gain_q;
      strobe_d    = 1'b0;
      overload_d  = overload_q;
      cnt_d       = cnt_q;
      peak_clear  = 1'b0;
      peak_update = 1'b0;
      decision    = agc_decide(peak, gain_q, HI_THRESH, LO_THRESH, GAIN_MAX);
      fast_hit    = 1'b0;
`ifdef AGC_FAST_ATTACK_EN
      fast_hit    = (demod_in >= FAST_ATTACK_LEVEL) && (gain_q != '0);
`endif

      // Dropping enable abandons the current window or settle period; gain holds.
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = MEASURE;
               peak_clear = 1'b1;
               cnt_d      = '0;
            end

            MEASURE: begin
               if (in_tick) begin
                  if (fast_hit) begin
                     gain_d   = gain_q - GAIN_W'(1);
                     strobe_d = 1'b1;
                     state_d  = SETTLE;
                     cnt_d    = '0;
                  end else begin
                     peak_update = 1'b1;
                     cnt_d       = cnt_q + CNT_W'(1);
                     if (cnt_q == WIN_LAST) begin
                        state_d = DECIDE;
                     end
                  end
               end
            end

            DECIDE: begin
               if (decision.ovl) begin
                  overload_d = 1'b1;
               end
               cnt_d = '0;
               if (decision.dec || decision.inc) begin
                  gain_d   = decision.dec ? (gain_q - GAIN_W'(1)) : (gain_q + GAIN_W'(1));
                  strobe_d = 1'b1;
                  state_d  = SETTLE;
               end else begin
                  state_d    = MEASURE;
                  peak_clear = 1'b1;
               end
            end

            SETTLE: begin
               if (in_tick) begin
                  if (cnt_q == HOLD_LAST) begin
                     state_d    = MEASURE;
                     peak_clear = 1'b1;
                     cnt_d      = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign gain_out    = gain_q;
   assign gain_strobe = strobe_q;
   assign overload    = overload_q;

endmodule

// File: tb/tb_agc_ctrl.sv
// Self-checking bench for agc_ctrl: vector table, directed corner sequences, and a
// randomized run against a window-level reference model.
module tb_agc_ctrl;
   import agc_pkg::*;

   localparam int unsigned WINDOW    = 8;
   localparam int unsigned HOLD      = 4;
   localparam logic [7:0]  GAIN_INIT = 8'd4;
   localparam logic [7:0]  GAIN_MAX  = 8'd7;
   localparam logic [15:0] HI        = 16'h0C00;
   localparam logic [15:0] LO        = 16'h0300;

   logic        clk = 1'b0;
   logic        RSTb = 1'b0;
   logic [15:0] demod_in = '0;
   logic        in_tick = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  gain_out;
   logic        gain_strobe;
   logic        overload;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   agc_ctrl #(
      .WINDOW    (WINDOW),
      .HOLD      (HOLD),
      .HI_THRESH (HI),
      .LO_THRESH (LO),
      .GAIN_INIT (GAIN_INIT),
      .GAIN_MAX  (GAIN_MAX)
   ) dut (
      .clk         (clk),
      .RSTb        (RSTb),
      .demod_in    (demod_in),
      .in_tick     (in_tick),
      .enable      (enable),
      .gain_out    (gain_out),
      .gain_strobe (gain_strobe),
      .overload    (overload)
   );

   typedef struct {
      logic [15:0] base;
      int unsigned pos;
      logic [15:0] peak;
      logic [7:0]  g;
      logic        s;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [15:0] v);
      in_tick  = 1'b1;
      demod_in = v;
      step();
      in_tick  = 1'b0;
   endtask

   task automatic ticks(input logic [15:0] v, input int unsigned n);
      for (int k = 0; k < int'(n); k++) tick(v);
   endtask

   task automatic do_reset();
      RSTb     = 1'b0;
      enable   = 1'b0;
      in_tick  = 1'b0;
      demod_in = '0;
      step();
      step();
      RSTb = 1'b1;
      step();
   endtask

   // Call right after the window-completing tick: one DECIDE cycle, then the outcome.
   task automatic expect_decision(input string name, input int unsigned g, input int unsigned s);
      chk({name, "_decide_strobe"}, 32'(gain_strobe), 0);
      step();
      chk({name, "_strobe"}, 32'(gain_strobe), s);
      chk({name, "_gain"}, 32'(gain_out), g);
   endtask

   task automatic run_table();
      tbl[0] = '{base: 16'h0100, pos: 0, peak: 16'h0100, g: 8'd5, s: 1'b1};
      tbl[1] = '{base: 16'h0000, pos: 5, peak: 16'h0D00, g: 8'd3, s: 1'b1};
      tbl[2] = '{base: 16'h0000, pos: 3, peak: 16'h0C00, g: 8'd4, s: 1'b0};
      tbl[3] = '{base: 16'h0000, pos: 7, peak: 16'h0300, g: 8'd4, s: 1'b0};
      tbl[4] = '{base: 16'h0000, pos: 0, peak: 16'h0C01, g: 8'd3, s: 1'b1};
      tbl[5] = '{base: 16'h0100, pos: 2, peak: 16'h02FF, g: 8'd5, s: 1'b1};
      tbl[6] = '{base: 16'h0500, pos: 4, peak: 16'h0700, g: 8'd4, s: 1'b0};
      tbl[7] = '{base: 16'h0300, pos: 6, peak: 16'h0300, g: 8'd4, s: 1'b0};
      for (int i = 0; i < 8; i++) begin
         do_reset();
         enable = 1'b1;
         step();
         for (int k = 0; k < int'(WINDOW); k++)
            tick((k == int'(tbl[i].pos)) ? tbl[i].peak : tbl[i].base);
         expect_decision($sformatf("vec%0d", i), 32'(tbl[i].g), 32'(tbl[i].s));
      end
   endtask

   task automatic run_climb_and_overload();
      do_reset();
      chk("reset_gain", 32'(gain_out), 32'(GAIN_INIT));
      chk("reset_strobe", 32'(gain_strobe), 0);
      chk("reset_overload", 32'(overload), 0);
      enable = 1'b1;
      step();
      ticks(16'h0100, WINDOW);
      expect_decision("up_w1", 5, 1);
      ticks(16'h0E00, HOLD);
      ticks(16'h0100, WINDOW);
      expect_decision("up_w2", 6, 1);
      ticks(16'h0E00, HOLD);
      ticks(16'h0100, WINDOW);
      expect_decision("up_w3", 7, 1);
      ticks(16'h0E00, HOLD);
      ticks(16'h0100, WINDOW);
      expect_decision("sat_hi", 7, 0);
      for (int g = 6; g >= 0; g--) begin
         ticks(16'h0E00, WINDOW);
         expect_decision($sformatf("down_to_%0d", g), 32'(g), 1);
         ticks(16'h0100, HOLD);
      end
      chk("ovl_before", 32'(overload), 0);
      ticks(16'h0E00, WINDOW);
      expect_decision("sat_lo", 0, 0);
      chk("ovl_set", 32'(overload), 1);
      ticks(16'h0100, WINDOW);
      expect_decision("ovl_sticky_up", 1, 1);
      chk("ovl_sticky", 32'(overload), 1);
      // Reset lands in the middle of the settle period.
      ticks(16'h0100, 2);
      RSTb = 1'b0;
      #1;
      chk("rst_settle_gain", 32'(gain_out), 32'(GAIN_INIT));
      chk("rst_settle_ovl", 32'(overload), 0);
      chk("rst_settle_strobe", 32'(gain_strobe), 0);
      step();
      RSTb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("post_rst_no_strobe", 32'(gain_strobe), 0);
      end
   endtask

   task automatic run_enable_drop();
      do_reset();
      enable = 1'b1;
      step();
      ticks(16'h0D00, 5);
      enable = 1'b0;
      step();
      step();
      chk("en_drop_gain", 32'(gain_out), 32'(GAIN_INIT));
      chk("en_drop_strobe", 32'(gain_strobe), 0);
      enable = 1'b1;
      step();
      ticks(16'h0100, 3);
      step();
      step();
      chk("en_fresh_no_strobe", 32'(gain_strobe), 0);
      chk("en_fresh_gain", 32'(gain_out), 32'(GAIN_INIT));
      ticks(16'h0100, 5);
      expect_decision("en_fresh_window", 5, 1);
   endtask

   task automatic run_fast_attack();
      do_reset();
      enable = 1'b1;
      step();
      tick(16'h0100);
      tick(16'h0100);
      tick(16'hF100);
`ifdef AGC_FAST_ATTACK_EN
      chk("fa_strobe", 32'(gain_strobe), 1);
      chk("fa_gain", 32'(gain_out), 3);
      chk("fa_state", 32'(dut.state_q), 32'(SETTLE));
`else
      chk("fa_off_strobe", 32'(gain_strobe), 0);
      chk("fa_off_gain", 32'(gain_out), 32'(GAIN_INIT));
      ticks(16'h0100, WINDOW - 3);
      expect_decision("fa_off_window", 3, 1);
`endif
   endtask

   // Window-level reference: collect measured samples, decide on their max, skip HOLD after a change.
   task automatic run_random();
      int unsigned m_gain;
      int unsigned exp_g;
      int unsigned settle_left;
      int unsigned cls;
      bit          m_ovl;
      logic [15:0] win [$];
      logic [15:0] v;
      logic [15:0] pk;
      m_gain      = 32'(GAIN_INIT);
      settle_left = 0;
      cls         = 0;
      m_ovl       = 1'b0;
      do_reset();
      enable = 1'b1;
      step();
      for (int i = 0; i < 600; i++) begin
         if (i % 8 == 0) cls = $urandom_range(0, 3);
         case (cls)
            0:       v = 16'($urandom_range(0, 16'h02FF));
            1:       v = 16'($urandom_range(16'h0300, 16'h0C00));
            2:       v = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h0C01, 16'hEFFF))
                                                     : 16'($urandom_range(0, 16'h0BFF));
            default: v = ($urandom_range(0, 1) == 1) ? 16'h0300 : 16'h0C00;
         endcase
         tick(v);
         if (settle_left > 0) begin
            settle_left--;
            chk("rnd_settle_strobe", 32'(gain_strobe), 0);
         end else begin
            win.push_back(v);
            if (win.size() == WINDOW) begin
               pk = '0;
               foreach (win[k]) if (win[k] > pk) pk = win[k];
               exp_g = m_gain;
               if (pk > HI && m_gain > 0) exp_g = m_gain - 1;
               else if (pk < LO && m_gain < 32'(GAIN_MAX)) exp_g = m_gain + 1;
               if (pk > HI && m_gain == 0) m_ovl = 1'b1;
               expect_decision("rnd", exp_g, (exp_g != m_gain) ? 1 : 0);
               chk("rnd_overload", 32'(overload), 32'(m_ovl));
               settle_left = (exp_g != m_gain) ? HOLD : 0;
               m_gain = exp_g;
               win.delete();
            end else begin
               chk("rnd_meas_strobe", 32'(gain_strobe), 0);
               chk("rnd_meas_gain", 32'(gain_out), m_gain);
            end
         end
         repeat ($urandom_range(0, 2)) step();
         if ($urandom_range(0, 49) == 0) begin
            enable = 1'b0;
            step();
            enable = 1'b1;
            step();
            chk("rnd_en_gain", 32'(gain_out), m_gain);
            win.delete();
            settle_left = 0;
         end
      end
   endtask

   initial begin
      run_table();
      run_climb_and_overload();
      run_enable_drop();
      run_fast_attack();
      run_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/agc_ctrl.md
AGC_CTRL -- requirements
Module: agc_ctrl

Interface
REQ-001 SHALL have parameter WINDOW, default 1024, the number of demod samples per measurement window.
REQ-002 SHALL have parameter HOLD, default 64, the number of samples ignored after a gain change while the datapath settles.
REQ-003 SHALL have parameter HI_THRESH, default 16'h0C00, the peak level above which gain decreases.
REQ-004 SHALL have parameter LO_THRESH, default 16'h0300, the peak level below which gain increases.
REQ-005 SHALL have parameter GAIN_INIT, default 8'd4, the gain value at reset.
REQ-006 SHALL have parameter GAIN_MAX, default 8'd31, the upper clamp on gain.
REQ-007 SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-008 SHALL have port RSTb, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port demod_in, input, 16 bits: unsigned AM demodulator output sample.
REQ-010 SHALL have port in_tick, input, 1 bit: one-cycle strobe marking demod_in valid.
REQ-011 SHALL have port enable, input, 1 bit: AGC loop run control.
REQ-012 SHALL have port gain_out, output, 8 bits: registered CIC gain setting.
REQ-013 SHALL have port gain_strobe, output, 1 bit: one-cycle pulse in the cycle gain_out takes a new value.
REQ-014 SHALL have port overload, output, 1 bit: sticky flag, set when a window peak exceeds HI_THRESH while gain_out is 0.

Function
REQ-015 SHALL implement states IDLE, MEASURE, DECIDE and SETTLE.
REQ-016 SHALL move IDLE->MEASURE on the first cycle enable is 1, clearing peak and the sample count.
REQ-017 SHALL, in MEASURE, on each in_tick set peak = max(peak, demod_in) and increment the sample count.
REQ-018 SHALL enter DECIDE in the cycle after the in_tick that brings the count to WINDOW.
REQ-019 SHALL hold DECIDE for exactly one cycle and ignore any in_tick in that cycle.
REQ-020 SHALL decide as follows: peak > HI_THRESH and gain > 0 -> gain-1; peak < LO_THRESH and gain < GAIN_MAX -> gain+1; otherwise unchanged (peaks equal to a threshold do not change gain).
REQ-021 SHALL, when gain changes, register the new value and pulse gain_strobe in the cycle after DECIDE, then enter SETTLE; when gain is unchanged, go to MEASURE with no strobe.
REQ-022 SHALL, in SETTLE, count HOLD in_ticks without measuring, then enter MEASURE with peak and count cleared.
REQ-023 SHALL clamp gain to the range 0..GAIN_MAX and never wrap.
REQ-024 SHALL, when enable drops in any state, go to IDLE on the next cycle, hold gain_out, and discard any partial window.
REQ-025 SHALL set overload when the REQ-014 condition is met at DECIDE; overload clears only on reset.
REQ-026 SHALL size the sample counter as $clog2(max(WINDOW,HOLD)+1) bits.

Reset
REQ-027 SHALL, while RSTb = 0, force state = IDLE, gain_out = GAIN_INIT, gain_strobe = 0, overload = 0, and peak and count = 0, asynchronously.
REQ-028 SHALL abandon a reset asserted mid-window or mid-SETTLE without producing a strobe.

Configuration
REQ-029 SHALL, with AGC_FAST_ATTACK_EN defined, treat an in_tick in MEASURE with demod_in >= 16'hF000 and gain > 0 as an immediate decision: decrement gain, strobe in the next cycle, and enter SETTLE without waiting for the window end.
REQ-030 SHALL, without AGC_FAST_ATTACK_EN, change gain only at window-end decisions.

Structure
REQ-031 SHALL place the state encoding and the default threshold, window and hold constants in shared package agc_pkg.
REQ-032 SHALL implement peak tracking (max register with clear) as sub-module agc_peak_detect.

Verification
Bench parameters for all scenarios: WINDOW=8, HOLD=4, GAIN_INIT=4, GAIN_MAX=7.
REQ-033 SHALL cover: reset release, enable=1, 8 ticks of 16'h0100 -> one strobe, gain 4->5; then 4 settle ticks and 8 more low ticks -> gain 6.
REQ-034 SHALL cover: 8 ticks where one sample is 16'h0D00 and the rest are 0 -> gain 4->3 with a single strobe.
REQ-035 SHALL cover: repeated low windows -> gain saturates at 7 with no strobe on the window after saturation; repeated 16'h0E00 windows -> gain reaches 0, then overload = 1.
REQ-036 SHALL cover: peak exactly 16'h0C00 or exactly 16'h0300 -> no gain change and no strobe.
REQ-037 SHALL cover: enable dropped after 5 ticks, then re-enabled -> next decision needs 8 fresh ticks; RSTb pulsed mid-SETTLE -> gain_out = 4, overload = 0.
REQ-038 SHALL cover: with AGC_FAST_ATTACK_EN, a 16'hF100 sample on the 3rd tick -> strobe 1 cycle later, gain 3, state SETTLE; without the macro -> no change until the window ends.
